// File: rtl/pmp_cfg_ctrl_if.sv
// Configuration write port of the PMP controller.
// The master side issues region writes with a valid/ready handshake and
// receives a one-cycle done pulse, qualified by err when the write was
// rejected. The slave side is the controller itself.
interface pmp_cfg_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_idx;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_limit;
    logic [2:0]        cfg_perm;
    logic              cfg_lock;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_perm, cfg_lock,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_perm, cfg_lock,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface

// File: rtl/pmp_cfg_ctrl.sv
// Physical-memory-protection configuration and fault controller.
// Holds NUM_REGIONS address ranges with {X,W,R} permissions and lock bits,
// programmed through a three-phase (IDLE/COMMIT/RESP) configuration FSM.
// Instruction-fetch and data-access checks are combinational from the
// current table; the first violation is latched into a sticky fault record.
// Optional feature: define PMP_FAULT_CNT_EN to build a saturating 8-bit
// per-cycle violation counter; otherwise fault_count is tied to zero.
module pmp_cfg_ctrl #(
    parameter int NUM_REGIONS    = 4,
    parameter int ADDR_W         = 8,
    parameter bit RST_ALL_ACCESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pmp_cfg_ctrl_if.slave     cfg,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_rd,
    input  logic              data_wr,
    output logic              instr_ok,
    output logic              data_ok,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [1:0]        fault_cause,
    input  logic              fault_clear,
    output logic [7:0]        fault_count
);

    localparam logic [3:0] NUM_REGIONS_W = 4'(NUM_REGIONS);
    localparam logic [1:0] CAUSE_FETCH   = 2'd0;
    localparam logic [1:0] CAUSE_LOAD    = 2'd1;
    localparam logic [1:0] CAUSE_STORE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RESP   = 2'd2
    } cfg_state_e;

    // One region entry; perm is {X,W,R}.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] limit;
        logic [2:0]        perm;
        logic              lock;
    } entry_t;

    typedef entry_t [NUM_REGIONS-1:0] table_t;

    // Captured configuration request, held through COMMIT.
    typedef struct packed {
        logic [2:0]        idx;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] limit;
        logic [2:0]        perm;
        logic              lock;
    } req_t;

    // Result of a table lookup: whether any region matched and its perms.
    typedef struct packed {
        logic       hit;
        logic [2:0] perm;
    } match_t;

    // Table contents after reset: optionally one all-access region 0.
    function automatic table_t reset_table();
        table_t t;
        t = '0;
        if (RST_ALL_ACCESS) begin
            t[0].base  = '0;
            t[0].limit = '1;
            t[0].perm  = 3'b111;
        end
        return t;
    endfunction

    // Lowest-index region containing addr decides; scanning downwards lets
    // the lowest hit overwrite any higher one.
    function automatic match_t lookup(input logic [ADDR_W-1:0] addr,
                                      input table_t            tbl);
        match_t m;
        m = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (addr >= tbl[i].base && addr <= tbl[i].limit) begin
                m.hit  = 1'b1;
                m.perm = tbl[i].perm;
            end
        end
        return m;
    endfunction

    cfg_state_e state_q, state_d;
    table_t     tbl_q, tbl_d;
    req_t       req_q, req_d;
    logic       cfg_ready_q, cfg_ready_d;
    logic       cfg_done_q, cfg_done_d;
    logic       cfg_err_q, cfg_err_d;

    logic              fault_valid_q, fault_valid_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic [1:0]        fault_cause_q, fault_cause_d;

    logic   req_reject;
    logic   target_locked;
    match_t instr_m;
    match_t data_m;
    logic   violation;

    // Reject decision for the held request, judged against the live table.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first so no path leaves it holding a value (no latch).
        target_locked = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (req_q.idx == 3'(i)) begin
                target_locked = tbl_q[i].lock;
            end
        end
        req_reject = ({1'b0, req_q.idx} >= NUM_REGIONS_W) ||
                     target_locked ||
                     (req_q.base > req_q.limit);
    end

    // Configuration FSM next state, table write and registered handshake outputs.
    always_comb begin
        state_d    = state_q;
        tbl_d      = tbl_q;
        req_d      = req_q;
        cfg_done_d = 1'b0;
        cfg_err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    req_d.idx   = cfg.cfg_idx;
                    req_d.base  = cfg.cfg_base;
                    req_d.limit = cfg.cfg_limit;
                    req_d.perm  = cfg.cfg_perm;
                    req_d.lock  = cfg.cfg_lock;
                    state_d     = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!req_reject) begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        if (req_q.idx == 3'(i)) begin
                            tbl_d[i].base  = req_q.base;
                            tbl_d[i].limit = req_q.limit;
                            tbl_d[i].perm  = req_q.perm;
                            tbl_d[i].lock  = req_q.lock;
                        end
                    end
                end
                cfg_done_d = 1'b1;
                cfg_err_d  = req_reject;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE);
    end

    // Configuration FSM state, table and handshake outputs; reset aborts any write.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignment so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            tbl_q       <= reset_table();
            cfg_ready_q <= 1'b1;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Request holding register, loaded only on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: the request register has no reset: it is only read in COMMIT,
        // which is always preceded by a capture. The table is reset because
        // its contents must be defined immediately after reset.
        req_q <= req_d;
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_done  = cfg_done_q;
    assign cfg.cfg_err   = cfg_err_q;

    // Zero-latency permission checks against the current table.
    always_comb begin
        instr_m  = lookup(instr_addr, tbl_q);
        data_m   = lookup(data_addr, tbl_q);
        instr_ok = instr_m.hit && instr_m.perm[2];
        data_ok  = !(data_rd || data_wr) ||
                   (data_m.hit && (!data_rd || data_m.perm[0])
                               && (!data_wr || data_m.perm[1]));
        violation = !instr_ok || !data_ok;
    end

    // Fault record next state: capture when empty or being cleared, fetch
    // before data, store before load.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_cause_d = fault_cause_q;
        if (violation && (!fault_valid_q || fault_clear)) begin
            fault_valid_d = 1'b1;
            if (!instr_ok) begin
                fault_addr_d  = instr_addr;
                fault_cause_d = CAUSE_FETCH;
            end else begin
                fault_addr_d  = data_addr;
                fault_cause_d = data_wr ? CAUSE_STORE : CAUSE_LOAD;
            end
        end else if (fault_clear) begin
            fault_valid_d = 1'b0;
        end
    end

    // Sticky fault record registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= CAUSE_FETCH;
        end else begin
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cause = fault_cause_q;

`ifdef PMP_FAULT_CNT_EN
    logic [7:0] fault_cnt_q, fault_cnt_d;

    // Saturating count of violating cycles, independent of the record.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (violation && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    // Violation counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_q <= 8'h00;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_count = fault_cnt_q;
`else
    assign fault_count = 8'h00;
`endif

endmodule
